// File: rtl/qif_pkg.sv
// Shared types, widths and the saturation helper for the time-multiplexed QIF neuron scheduler.
package qif_pkg;

  localparam int V_W   = 8;
  localparam int SUM_W = 11;
  localparam int REF_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic signed [SUM_W-1:0] V_MAX_S = SUM_W'(2**V_W - 1);

  // Saturate a signed membrane sum into the unsigned voltage range.
  function automatic logic [V_W-1:0] clamp_v(input logic signed [SUM_W-1:0] s);
    if (s < 0) return '0;
    if (s > V_MAX_S) return '1;
    return s[V_W-1:0];
  endfunction

endpackage

// File: rtl/qif_core.sv
// Combinational QIF update for one neuron: V + V*V>>SQ_SHIFT + B - LEAK, clamp, threshold, refractory.
module qif_core
  import qif_pkg::*;
#(
  parameter int V_TH     = 200,
  parameter int V_RESET  = 0,
  parameter int LEAK     = 1,
  parameter int SQ_SHIFT = 8,
  parameter int REFRAC   = 2
) (
  input  logic [V_W-1:0]   v,
  input  logic [V_W-1:0]   b,
  input  logic [REF_W-1:0] refrac,
  output logic [V_W-1:0]   v_next,
  output logic [REF_W-1:0] refrac_next,
  output logic             spike
);

  logic [2*V_W-1:0] prod;
  logic [SUM_W-2:0] sq;
  logic [SUM_W-1:0] sum;
  logic [V_W-1:0]   s_clamped;

  assign prod = (2*V_W)'(v) * (2*V_W)'(v);
  assign sq   = (SUM_W-1)'(prod >> SQ_SHIFT);
  // Two's-complement wrap of the unsigned sum gives the signed value; LEAK can push it below zero.
  assign sum  = SUM_W'(v) + SUM_W'(sq) + SUM_W'(b) - SUM_W'(LEAK);
  assign s_clamped = clamp_v(signed'(sum));

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    v_next      = V_W'(V_RESET);
    refrac_next = '0;
    spike       = 1'b0;
    if (refrac != '0) begin
      refrac_next = refrac - 1'b1;
    end else if (s_clamped >= V_W'(V_TH)) begin
      spike       = 1'b1;
      refrac_next = REF_W'(REFRAC);
    end else begin
      v_next = s_clamped;
    end
  end

endmodule

// File: rtl/qif_scheduler.sv
// Sweeps N_NEURONS virtual QIF neurons through one shared datapath per tick; spikes leave as IDs on a FIFO stream.
module qif_scheduler
  import qif_pkg::*;
#(
  parameter  int N_NEURONS  = 4,
  parameter  int V_TH       = 200,
  parameter  int V_RESET    = 0,
  parameter  int LEAK       = 1,
  parameter  int SQ_SHIFT   = 8,
  parameter  int REFRAC     = 2,
  parameter  int FIFO_DEPTH = 4,
  localparam int IDW        = $clog2(N_NEURONS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           cfg_we,
  input  logic [IDW-1:0] cfg_addr,
  input  logic [7:0]     cfg_data,
  input  logic [IDW-1:0] mon_addr,
  output logic [7:0]     mon_v,
  output logic           busy,
  output logic           done,
  output logic           overrun,
  output logic           spk_valid,
  input  logic           spk_ready,
  output logic [IDW-1:0] spk_id
);

  localparam int FW = $clog2(FIFO_DEPTH);

  state_t           state;
  logic [IDW-1:0]   idx;
  logic [V_W-1:0]   v_mem [N_NEURONS];
  logic [V_W-1:0]   b_mem [N_NEURONS];
  logic [REF_W-1:0] r_mem [N_NEURONS];

  logic [IDW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [FW-1:0]    wr_ptr, rd_ptr;
  logic [FW:0]      count;

  logic [V_W-1:0]   v_next;
  logic [REF_W-1:0] r_next;
  logic             spike;
  logic             fifo_full, commit, push, pop;

  qif_core #(
    .V_TH(V_TH), .V_RESET(V_RESET), .LEAK(LEAK), .SQ_SHIFT(SQ_SHIFT), .REFRAC(REFRAC)
  ) u_core (
    .v(v_mem[idx]), .b(b_mem[idx]), .refrac(r_mem[idx]),
    .v_next(v_next), .refrac_next(r_next), .spike(spike)
  );

  // Stall uses the count at the start of the cycle; a simultaneous pop does not free the slot.
  assign fifo_full = (count == (FW+1)'(FIFO_DEPTH));
  assign commit    = (state == RUN) && !(spike && fifo_full);
  assign push      = commit && spike;
  assign spk_valid = (count != '0);
  assign pop       = spk_valid && spk_ready;
  assign spk_id    = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of statement order.
      if (tick && busy) overrun <= 1'b1;
      case (state)
        IDLE: if (tick) begin
          state <= RUN;
          idx   <= '0;
          busy  <= 1'b1;
        end
        RUN: if (commit) begin
          if (idx == IDW'(N_NEURONS - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the banks are plain flops, not a RAM macro, so they take the async reset like any other state.
      for (int i = 0; i < N_NEURONS; i++) begin
        v_mem[i] <= V_W'(V_RESET);
        b_mem[i] <= '0;
        r_mem[i] <= '0;
      end
      mon_v <= V_W'(V_RESET);
    end else begin
      if (commit) begin
        v_mem[idx] <= v_next;
        r_mem[idx] <= r_next;
      end
      if (cfg_we) b_mem[cfg_addr] <= cfg_data;
      mon_v <= v_mem[mon_addr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= idx;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (FW+1)'(push) - (FW+1)'(pop);
    end
  end

endmodule

// File: doc/qif_scheduler.md
Name: qif_scheduler

Overview:
Time-multiplexes a single QIF (quadratic integrate-and-fire) update datapath across N_NEURONS virtual neurons. It holds each neuron's membrane voltage, bias input and refractory count in register banks. On each time-step tick it sweeps all neurons once, one per cycle. Spikes are queued as neuron-ID events on a valid/ready stream, so it sits between the host/config logic and the spike-routing fabric.

Parameters:
N_NEURONS, 4, number of virtual neurons (power of 2, >=2)
V_TH, 200, spike threshold (8-bit, unsigned)
V_RESET, 0, post-spike and reset membrane value
LEAK, 1, constant subtracted per update
SQ_SHIFT, 8, right shift applied to V*V
REFRAC, 2, refractory length in ticks (0 disables; max 15)
FIFO_DEPTH, 4, spike event FIFO depth (power of 2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
tick  in  1  single-cycle pulse: start one time step
cfg_we  in  1  bias write strobe
cfg_addr  in  IDW  neuron index for bias write (IDW = clog2(N_NEURONS))
cfg_data  in  8  bias value B (unsigned)
mon_addr  in  IDW  membrane readback index
mon_v  out  8  membrane voltage of mon_addr, registered
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at sweep end
overrun  out  1  sticky: tick arrived while busy
spk_valid  out  1  spike event available
spk_ready  in  1  consumer accepts event
spk_id  out  IDW  neuron index of head event

Behaviour:
- Reset (rst=0, async): all V = V_RESET, all bias = 0, all refrac = 0; FSM IDLE; busy=0, done=0, overrun=0, mon_v=V_RESET; FIFO empty, spk_valid=0, spk_id=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: tick=1 -> RUN, idx=0.
  - RUN: process neuron idx. If committed and idx==N_NEURONS-1 -> DONE, else idx+1.
  - DONE: done=1 for exactly this cycle -> IDLE.
- busy=1 in RUN and DONE. First neuron is updated in the cycle after tick. An unstalled sweep takes N_NEURONS cycles, then 1 DONE cycle.
- Any tick while busy=1 is ignored and sets overrun=1. overrun clears only on reset.
- Update per neuron (combinational, committed at clock edge):
  - refrac>0: V <= V_RESET, refrac <= refrac-1, no spike.
  - otherwise: sq = (V*V)>>SQ_SHIFT (16-bit product); s = V + sq + B - LEAK in 11-bit signed; clamp s to [0,255].
  - Clamped s >= V_TH: spike. V <= V_RESET, refrac <= REFRAC, push idx into FIFO.
  - Else V <= clamped s.
- Stall: spike needed and FIFO count==FIFO_DEPTH at start of cycle. Idx is held and nothing is committed; retry each cycle. A same-cycle pop does not release the stall.
- FIFO: push and pop in the same non-full cycle are both accepted. Pop occurs when spk_valid && spk_ready. spk_valid = !empty; spk_id = head entry.
- Bias writes are accepted in any state. A write to the idx being processed in that cycle takes effect from the next sweep; the current update uses the old B.
- mon_v <= V[mon_addr] each cycle (1-cycle latency), reflecting committed state.
- N-neuron index wraps only via FSM; idx is never advanced past N_NEURONS-1.

Decomposition:
- Package qif_pkg: state enum (IDLE/RUN/DONE), default widths (V_W=8, SUM_W=11, REF_W=4), clamp helper function.
- Sub-module qif_core: purely combinational. Inputs V, B, refrac; outputs v_next, refrac_next, spike. Instantiated once.
- FIFO stays inline.

Test Plan:
- Reset mid-sweep: assert rst at sweep cycle 2 -> all outputs return to reset values immediately; mon_v of every neuron reads 0.
- Integration/spike, defaults, bias[0]=50, repeated ticks, spk_ready=1 -> V0 = 49, 107, then spike on tick 3. spk_id=0, V0=0, stays 0 for ticks 4-5, reads 49 after tick 6.
- Sweep timing: tick at cycle t -> busy rises t+1, done pulses at t+5 (N=4), busy low at t+6. A second tick at t+2 sets overrun=1 and the sweep length is unchanged.
- Backpressure: all biases=255, spk_ready=0 -> tick 1 spikes all 4 neurons, FIFO fills with ids 0,1,2,3 in order. Next tick with REFRAC=0 stalls at idx 0 (busy held, no done). Raising spk_ready drains the FIFO and the sweep resumes.
- Clamp: bias=0, V_TH=255 -> V stays 0 (s=-1 clamps to 0), no spikes. Bias=255 with V=200 -> clamped to 255 and spikes.
- Config collision: write bias[2]=100 in the cycle neuron 2 is processed -> that update uses old bias; the next sweep uses 100.
